// File: rtl/minisys_pkg.sv
// -----------------------------------------------------------------------------
// minisys_pkg
// Shared definitions for the MiniSys-1A pipeline:
//   - datapath widths DW / RW
//   - ALU opcode encoding (ALU_NOP = 0, real operations 1..13)
//   - REG_ZERO, the hard-wired zero register index
//   - forwarding-select enum used by fwd_unit
//   - ID/EX stage register layout and its bubble value
// -----------------------------------------------------------------------------
package minisys_pkg;

    localparam int DW = 32;
    localparam int RW = 5;

    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_AND  = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_SLTU = 4'd8;
    localparam logic [3:0] ALU_SLL  = 4'd9;
    localparam logic [3:0] ALU_SRL  = 4'd10;
    localparam logic [3:0] ALU_SRA  = 4'd11;
    localparam logic [3:0] ALU_LUI  = 4'd12;
    localparam logic [3:0] ALU_ADDU = 4'd13;

    localparam logic [RW-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_EXM = 2'd1,
        FWD_MWB = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [DW-1:0] imm;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] rd;
        logic [3:0]    alu_control;
        logic          alusrc;
        logic          regwrite;
        logic          memread;
        logic          memwrite;
    } id_ex_t;

    // A bubble is the all-zero stage word: valid=0, ALU_NOP, no side effects,
    // data fields zeroed.
    localparam id_ex_t STAGE_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// -----------------------------------------------------------------------------
// id_ex_if
// Bundles every signal crossing the ID/EX stage boundary except clk/rst_n.
//   master : the surrounding pipeline (decode, EX/MEM, MEM/WB, hazard control)
//   slave  : id_ex_stage
// Decode side   : id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt,
//                 id_rd, id_alu_control, id_alusrc, id_regwrite, id_memread,
//                 id_memwrite
// Forward side  : exm_regwrite, exm_rd, exm_result, mwb_regwrite, mwb_rd,
//                 mwb_result
// Control       : flush, hold (in), stall (out)
// EX side (out) : alu_a, alu_b, alu_control, ex_valid, ex_regwrite,
//                 ex_memread, ex_memwrite, ex_rd, ex_store_data
// -----------------------------------------------------------------------------
interface id_ex_if;
    import minisys_pkg::*;

    logic          id_valid;
    logic [DW-1:0] id_rs_data;
    logic [DW-1:0] id_rt_data;
    logic [DW-1:0] id_imm;
    logic [RW-1:0] id_rs;
    logic [RW-1:0] id_rt;
    logic [RW-1:0] id_rd;
    logic [3:0]    id_alu_control;
    logic          id_alusrc;
    logic          id_regwrite;
    logic          id_memread;
    logic          id_memwrite;

    logic          exm_regwrite;
    logic [RW-1:0] exm_rd;
    logic [DW-1:0] exm_result;
    logic          mwb_regwrite;
    logic [RW-1:0] mwb_rd;
    logic [DW-1:0] mwb_result;

    logic          flush;
    logic          hold;
    logic          stall;

    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [3:0]    alu_control;
    logic          ex_valid;
    logic          ex_regwrite;
    logic          ex_memread;
    logic          ex_memwrite;
    logic [RW-1:0] ex_rd;
    logic [DW-1:0] ex_store_data;

    modport master (
        output id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
               id_alu_control, id_alusrc, id_regwrite, id_memread, id_memwrite,
               exm_regwrite, exm_rd, exm_result, mwb_regwrite, mwb_rd, mwb_result,
               flush, hold,
        input  stall, alu_a, alu_b, alu_control, ex_valid, ex_regwrite,
               ex_memread, ex_memwrite, ex_rd, ex_store_data
    );

    modport slave (
        input  id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
               id_alu_control, id_alusrc, id_regwrite, id_memread, id_memwrite,
               exm_regwrite, exm_rd, exm_result, mwb_regwrite, mwb_rd, mwb_result,
               flush, hold,
        output stall, alu_a, alu_b, alu_control, ex_valid, ex_regwrite,
               ex_memread, ex_memwrite, ex_rd, ex_store_data
    );

endinterface

// File: rtl/id_ex_stage_fwd_unit.sv
// -----------------------------------------------------------------------------
// fwd_unit
// Operand bypass for one source register: compares the registered index
// against the EX/MEM and MEM/WB destinations and selects the newest value.
//   idx          : registered source index
//   reg_data     : registered register-file data for idx
//   exm_*        : EX/MEM write-back port (regwrite, rd, result)
//   mwb_*        : MEM/WB write-back port (regwrite, rd, result)
//   data         : forwarded operand (combinational)
// -----------------------------------------------------------------------------
module fwd_unit
    import minisys_pkg::*;
(
    input  logic [RW-1:0] idx,
    input  logic [DW-1:0] reg_data,
    input  logic          exm_regwrite,
    input  logic [RW-1:0] exm_rd,
    input  logic [DW-1:0] exm_result,
    input  logic          mwb_regwrite,
    input  logic [RW-1:0] mwb_rd,
    input  logic [DW-1:0] mwb_result,
    output logic [DW-1:0] data
);

    fwd_sel_e sel;

    // EX/MEM is younger than MEM/WB, so it is checked first. A destination
    // of r0 never matches, so a source index of r0 always reads reg_data.
    always_comb begin
        sel = FWD_REG;
        if (exm_regwrite && (exm_rd != REG_ZERO) && (exm_rd == idx)) begin
            sel = FWD_EXM;
        end else if (mwb_regwrite && (mwb_rd != REG_ZERO) && (mwb_rd == idx)) begin
            sel = FWD_MWB;
        end
    end

    always_comb begin
        data = reg_data;
        case (sel)
            FWD_EXM: data = exm_result;
            FWD_MWB: data = mwb_result;
            default: data = reg_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register of the MiniSys-1A CPU, feeding alu_32.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : id_ex_if.slave carrying decode inputs, forwarding sources,
//                flush/hold, and the stall / ALU / EX-control outputs
// The stage register captures decoded operands and control. Operands are
// bypassed combinationally from EX/MEM and MEM/WB. A load followed by a
// dependent instruction stalls decode once and inserts a bubble.
// Edge priority: flush > hold > load-use bubble > capture.
// -----------------------------------------------------------------------------
module id_ex_stage
    import minisys_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    id_ex_if.slave    bus
);

    id_ex_t        ex_p1;
    id_ex_t        ex_next;
    logic          load_use;
    logic [DW-1:0] rs_fwd;
    logic [DW-1:0] rt_fwd;

    // rt only matters to the incoming instruction when it is a register
    // operand (alusrc=0) or store data (memwrite=1).
    always_comb begin
        load_use = bus.id_valid && ex_p1.valid && ex_p1.memread &&
                   (ex_p1.rd != REG_ZERO) &&
                   ((ex_p1.rd == bus.id_rs) ||
                    ((ex_p1.rd == bus.id_rt) && (!bus.id_alusrc || bus.id_memwrite)));
    end

    // Flush or hold already keep decode from advancing usefully, so stall
    // is only raised when the load-use bubble is what actually happens.
    assign bus.stall = load_use && !bus.flush && !bus.hold;

    always_comb begin
        ex_next = ex_p1;
        if (bus.flush) begin
            ex_next = STAGE_BUBBLE;
        end else if (bus.hold) begin
            ex_next = ex_p1;
        end else if (load_use || !bus.id_valid) begin
            ex_next = STAGE_BUBBLE;
        end else begin
            ex_next.valid       = 1'b1;
            ex_next.rs_data     = bus.id_rs_data;
            ex_next.rt_data     = bus.id_rt_data;
            ex_next.imm         = bus.id_imm;
            ex_next.rs          = bus.id_rs;
            ex_next.rt          = bus.id_rt;
            ex_next.rd          = bus.id_rd;
            ex_next.alu_control = bus.id_alu_control;
            ex_next.alusrc      = bus.id_alusrc;
            ex_next.regwrite    = bus.id_regwrite;
            ex_next.memread     = bus.id_memread;
            ex_next.memwrite    = bus.id_memwrite;
        end
    end

    // ---- ID -> EX stage boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_p1 <= STAGE_BUBBLE;
        end else begin
            ex_p1 <= ex_next;
        end
    end

    fwd_unit u_fwd_rs (
        .idx          (ex_p1.rs),
        .reg_data     (ex_p1.rs_data),
        .exm_regwrite (bus.exm_regwrite),
        .exm_rd       (bus.exm_rd),
        .exm_result   (bus.exm_result),
        .mwb_regwrite (bus.mwb_regwrite),
        .mwb_rd       (bus.mwb_rd),
        .mwb_result   (bus.mwb_result),
        .data         (rs_fwd)
    );

    fwd_unit u_fwd_rt (
        .idx          (ex_p1.rt),
        .reg_data     (ex_p1.rt_data),
        .exm_regwrite (bus.exm_regwrite),
        .exm_rd       (bus.exm_rd),
        .exm_result   (bus.exm_result),
        .mwb_regwrite (bus.mwb_regwrite),
        .mwb_rd       (bus.mwb_rd),
        .mwb_result   (bus.mwb_result),
        .data         (rt_fwd)
    );

    assign bus.alu_a         = rs_fwd;
    assign bus.alu_b         = ex_p1.alusrc ? ex_p1.imm : rt_fwd;
    assign bus.ex_store_data = rt_fwd;
    assign bus.alu_control   = ex_p1.alu_control;
    assign bus.ex_valid      = ex_p1.valid;
    assign bus.ex_regwrite   = ex_p1.regwrite;
    assign bus.ex_memread    = ex_p1.memread;
    assign bus.ex_memwrite   = ex_p1.memwrite;
    assign bus.ex_rd         = ex_p1.rd;

endmodule
